// File: rtl/neuron_sequencer.sv
// Binary-input neuron: N_IN signed weights held in a register file, evaluated
// one multiply-add per cycle through a single shared accumulator.
module neuron_sequencer #(
  parameter int N_IN  = 5,
  parameter int W_W   = 10,
  parameter int ACC_W = 24,
  localparam int AW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic signed [W_W-1:0]   w_data,
  input  logic                    start,
  input  logic [N_IN-1:0]         in_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    out_val,
  output logic signed [ACC_W-1:0] acc_out
);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [N_IN-1:0]         vec_q, vec_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    done_q, done_d;
  logic                    out_val_q, out_val_d;

  logic signed [W_W-1:0]   weight_q [N_IN];
  logic signed [W_W-1:0]   w_sel;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;

  // Writes are only honoured while idle so a running evaluation sees a frozen weight set.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_weight
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        weight_q[gi] <= '0;
      end else if (w_we && (state_q == IDLE) && (w_addr == AW'(gi))) begin
        weight_q[gi] <= w_data;
      end
    end
  end

  assign w_sel  = weight_q[idx_q];
  assign addend = vec_q[idx_q] ? {{(ACC_W-W_W){w_sel[W_W-1]}}, w_sel} : '0;
  assign sum    = acc_q + addend;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    out_val_d = out_val_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = in_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(N_IN - 1)) begin
          idx_d     = '0;
          state_d   = IDLE;
          acc_out_d = sum;
          out_val_d = (sum > 0);
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vec_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      out_val_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      out_val_q <= out_val_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == MAC);
  assign done    = done_q;
  assign out_val = out_val_q;
  assign acc_out = acc_out_q;

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter N_IN, default 5: number of neuron inputs and weights.
REQ-002 Parameter W_W, default 10: signed weight width.
REQ-003 Parameter ACC_W, default 24: signed accumulator width.
REQ-004 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 w_we  input  1  weight write strobe.
REQ-008 w_addr  input  ceil(log2(N_IN))  weight index to write.
REQ-009 w_data  input  W_W  signed weight value.
REQ-010 start  input  1  request one evaluation.
REQ-011 in_vec  input  N_IN  binary neuron inputs; bit i pairs with weight i.
REQ-012 busy  output  1  evaluation in progress.
REQ-013 done  output  1  one-cycle result-valid pulse.
REQ-014 out_val  output  1  activation result, held until next done.
REQ-015 acc_out  output  ACC_W  signed weighted sum, held until next done.

Function
REQ-016 Weights SHALL reside in an internal N_IN x W_W register file; only one weight multiply-add SHALL occur per cycle through a single shared datapath.
REQ-017 A write with w_we=1 in any non-MAC cycle SHALL update weight[w_addr] at that edge; a write with w_addr >= N_IN SHALL be ignored.
REQ-018 A write while state=MAC SHALL be ignored, with no effect on the weights or the running evaluation.
REQ-019 State machine SHALL have states IDLE and MAC.
REQ-020 IDLE with start=1 at edge t SHALL latch in_vec, clear the accumulator, set idx=0 and enter MAC.
REQ-021 In MAC, each edge SHALL add (in_vec_l[idx] ? sign-extended weight[idx] : 0) to acc and increment idx.
REQ-022 The edge at idx=N_IN-1 SHALL perform the last add and return to IDLE.
REQ-023 At that same edge, acc_out SHALL load the final sum, out_val SHALL load (final sum > 0), and done SHALL be set.
REQ-024 Latency: with start sampled at edge t, done=1 during the cycle after edge t+N_IN (6 cycles for N_IN=5).
REQ-025 done SHALL stay high for exactly one cycle.
REQ-026 busy SHALL be 1 exactly while state=MAC.
REQ-027 start while busy SHALL be ignored and not queued.
REQ-028 start high in the done cycle SHALL be accepted, allowing back-to-back evaluations with no dead cycle.
REQ-029 Arithmetic SHALL be two's complement and sign-extended to ACC_W; with ACC_W >= W_W+ceil(log2(N_IN)) no overflow occurs, and no saturation logic is required.
REQ-030 A sum of exactly 0 SHALL give out_val=0.
REQ-031 Changes on in_vec after the start edge SHALL not affect the running evaluation.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, acc=0, busy=0, done=0, out_val=0, acc_out=0, and all weights=0.
REQ-033 Reset asserted mid-MAC SHALL abort the evaluation with no done pulse; the first start after release SHALL begin a fresh evaluation.

Verification
REQ-034 Weights {3,-2,5,1,-4}, in_vec=5'b10101 (bits 0,2,4 set), start at edge t -> busy during cycles t+1..t+5, done in cycle t+6, acc_out=4, out_val=1.
REQ-035 Same weights, in_vec=5'b10010 -> acc_out=-6, out_val=0; in_vec=5'b00000 -> acc_out=0, out_val=0.
REQ-036 All weights -512, in_vec=5'b11111 -> acc_out=-2560; all weights 511 -> acc_out=2555, out_val=1.
REQ-037 start held high continuously -> done every 6 cycles; in_vec toggled and a weight write issued mid-MAC -> results reflect only pre-start values.
REQ-038 rst_n pulsed low during the third MAC cycle -> busy=0 and done=0 immediately, weights=0; after release, start with any in_vec -> acc_out=0, out_val=0.
